// File: rtl/sample_accumulator.sv
// Burst front end for the external 11-bit ripple-carry adder: feeds acc and each
// sample to the adder, registers Sum back, and hands the total downstream.
module sample_accumulator #(
    parameter int N_SAMPLES = 8,
    parameter int DATA_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [10:0]       add_a,
    output logic [10:0]       add_b,
    output logic              add_cin,
    input  logic [10:0]       add_sum,
    input  logic              add_cout,
    output logic              out_valid,
    output logic [10:0]       out_sum,
    input  logic              out_ack,
    output logic              busy,
    output logic              overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] LAST_COUNT = 8'(N_SAMPLES);

    state_t      state;
    logic [10:0] acc;
    logic [7:0]  count;
    logic [7:0]  count_next;
    logic        accept;

    assign add_a      = acc;
    assign add_b      = 11'(in_data);
    assign add_cin    = 1'b0;
    assign out_sum    = acc;
    assign accept     = in_valid && in_ready;
    assign count_next = count + 8'd1;

    // Flags are registered alongside the state so they change only on clock edges
    // (or immediately under reset); acc is left alone on exit so out_sum persists.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= 11'd0;
            count     <= 8'd0;
            overflow  <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= ACCUM;
                        acc      <= 11'd0;
                        count    <= 8'd0;
                        overflow <= 1'b0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc      <= add_sum;
                        count    <= count_next;
                        overflow <= overflow | add_cout;
                        if (count_next == LAST_COUNT) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ack) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sample_accumulator.sv
// Directed bench for sample_accumulator: default 8x8-bit instance plus an
// 11-bit, 2-sample instance for the overflow case; both drive a behavioural adder.
module tb_sample_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, in_valid, out_ack;
    logic [7:0]  in_data;
    logic        in_ready, add_cin, out_valid, busy, overflow, add_cout;
    logic [10:0] add_a, add_b, add_sum, out_sum;

    logic        w_start, w_in_valid, w_out_ack;
    logic [10:0] w_in_data;
    logic        w_in_ready, w_add_cin, w_out_valid, w_busy, w_overflow, w_add_cout;
    logic [10:0] w_add_a, w_add_b, w_add_sum, w_out_sum;

    int pass_count  = 0;
    int check_count = 0;

    always #5 clk = ~clk;

    // Behavioural stand-in for the 11-bit ripple-carry adder
    assign {add_cout, add_sum}     = {1'b0, add_a} + {1'b0, add_b} + {11'd0, add_cin};
    assign {w_add_cout, w_add_sum} = {1'b0, w_add_a} + {1'b0, w_add_b} + {11'd0, w_add_cin};

    sample_accumulator dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout), .out_valid(out_valid), .out_sum(out_sum),
        .out_ack(out_ack), .busy(busy), .overflow(overflow)
    );

    sample_accumulator #(.N_SAMPLES(2), .DATA_W(11)) dut_wide (
        .clk(clk), .rst(rst), .start(w_start), .in_valid(w_in_valid), .in_data(w_in_data),
        .in_ready(w_in_ready), .add_a(w_add_a), .add_b(w_add_b), .add_cin(w_add_cin),
        .add_sum(w_add_sum), .add_cout(w_add_cout), .out_valid(w_out_valid),
        .out_sum(w_out_sum), .out_ack(w_out_ack), .busy(w_busy), .overflow(w_overflow)
    );

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] v);
        in_valid = 1'b1;
        in_data  = v;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'hA5;
    endtask

    task automatic pulse_ack();
        out_ack = 1'b1;
        @(negedge clk);
        out_ack = 1'b0;
    endtask

    task automatic test_reset();
        check_count++;
        if ({in_ready, out_valid, busy, overflow} !== 4'b0000)
            $display("[TB] FAIL reset_flags: got %b expected 0000", {in_ready, out_valid, busy, overflow});
        else pass_count++;
        check_count++;
        if (out_sum !== 11'd0 || add_a !== 11'd0 || add_cin !== 1'b0)
            $display("[TB] FAIL reset_data: out_sum=%0d add_a=%0d add_cin=%b expected 0", out_sum, add_a, add_cin);
        else pass_count++;
    endtask

    task automatic test_basic_burst();
        pulse_start();
        check_count++;
        if (in_ready !== 1'b1 || busy !== 1'b1)
            $display("[TB] FAIL basic_start: in_ready=%b busy=%b expected 1 1", in_ready, busy);
        else pass_count++;
        for (int i = 1; i <= 8; i++) begin
            send(8'(i));
            check_count++;
            if (out_valid !== (i == 8))
                $display("[TB] FAIL basic_valid_%0d: got %b expected %b", i, out_valid, (i == 8));
            else pass_count++;
        end
        check_count++;
        if (out_sum !== 11'd36 || overflow !== 1'b0 || in_ready !== 1'b0)
            $display("[TB] FAIL basic_result: sum=%0d ovf=%b rdy=%b expected 36 0 0", out_sum, overflow, in_ready);
        else pass_count++;
        pulse_ack();
        check_count++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_sum !== 11'd36)
            $display("[TB] FAIL basic_ack: valid=%b busy=%b sum=%0d expected 0 0 36", out_valid, busy, out_sum);
        else pass_count++;
    endtask

    task automatic test_max_values();
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hFF;
            check_count++;
            if (add_cin !== 1'b0 || add_b !== 11'h0FF)
                $display("[TB] FAIL max_adder_in_%0d: cin=%b b=%h expected 0 0ff", i, add_cin, add_b);
            else pass_count++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check_count++;
        if (out_valid !== 1'b1 || out_sum !== 11'h7F8 || overflow !== 1'b0)
            $display("[TB] FAIL max_result: valid=%b sum=%h ovf=%b expected 1 7f8 0", out_valid, out_sum, overflow);
        else pass_count++;
        pulse_ack();
    endtask

    task automatic test_bubbles();
        logic [7:0] vals [8] = '{8'd10, 8'd0, 8'd200, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5};
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            send(vals[i]);
            if (i < 7) repeat (3) @(negedge clk);
        end
        for (int c = 0; c < 5; c++) begin
            check_count++;
            if (out_valid !== 1'b1 || out_sum !== 11'd235 || busy !== 1'b1)
                $display("[TB] FAIL bubble_hold_%0d: valid=%b sum=%0d busy=%b expected 1 235 1", c, out_valid, out_sum, busy);
            else pass_count++;
            @(negedge clk);
        end
        out_ack = 1'b1;
        check_count++;
        if (busy !== 1'b1)
            $display("[TB] FAIL bubble_busy_at_ack: got %b expected 1", busy);
        else pass_count++;
        @(negedge clk);
        out_ack = 1'b0;
        check_count++;
        if (busy !== 1'b0 || out_valid !== 1'b0)
            $display("[TB] FAIL bubble_after_ack: busy=%b valid=%b expected 0 0", busy, out_valid);
        else pass_count++;
    endtask

    task automatic test_ignored_events();
        pulse_start();
        repeat (4) send(8'd1);
        pulse_start();
        repeat (4) send(8'd1);
        check_count++;
        if (out_valid !== 1'b1 || out_sum !== 11'd8)
            $display("[TB] FAIL mid_start: valid=%b sum=%0d expected 1 8", out_valid, out_sum);
        else pass_count++;
        pulse_start();
        check_count++;
        if (out_valid !== 1'b1 || out_sum !== 11'd8 || in_ready !== 1'b0)
            $display("[TB] FAIL done_start: valid=%b sum=%0d rdy=%b expected 1 8 0", out_valid, out_sum, in_ready);
        else pass_count++;
        start   = 1'b1;
        out_ack = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        out_ack = 1'b0;
        check_count++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0)
            $display("[TB] FAIL start_with_ack: rdy=%b busy=%b valid=%b expected 0 0 0", in_ready, busy, out_valid);
        else pass_count++;
        pulse_ack();
        check_count++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 || out_sum !== 11'd8)
            $display("[TB] FAIL idle_ack: rdy=%b busy=%b valid=%b sum=%0d expected 0 0 0 8", in_ready, busy, out_valid, out_sum);
        else pass_count++;
    endtask

    task automatic test_async_reset();
        pulse_start();
        repeat (4) send(8'd5);
        #2 rst = 1'b1;
        #1;
        check_count++;
        if ({in_ready, out_valid, busy} !== 3'b000 || out_sum !== 11'd0)
            $display("[TB] FAIL async_reset: flags=%b sum=%0d expected 000 0", {in_ready, out_valid, busy}, out_sum);
        else pass_count++;
        #1 rst = 1'b0;
        @(negedge clk);
        pulse_start();
        repeat (8) send(8'd3);
        check_count++;
        if (out_valid !== 1'b1 || out_sum !== 11'd24)
            $display("[TB] FAIL post_reset_burst: valid=%b sum=%0d expected 1 24", out_valid, out_sum);
        else pass_count++;
        pulse_ack();
    endtask

    task automatic test_overflow();
        logic [10:0] vals [2] = '{11'h7FF, 11'h002};
        w_start = 1'b1;
        @(negedge clk);
        w_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            w_in_valid = 1'b1;
            w_in_data  = vals[i];
            @(negedge clk);
        end
        w_in_valid = 1'b0;
        check_count++;
        if (w_out_valid !== 1'b1 || w_out_sum !== 11'h001 || w_overflow !== 1'b1)
            $display("[TB] FAIL wide_overflow: valid=%b sum=%h ovf=%b expected 1 001 1", w_out_valid, w_out_sum, w_overflow);
        else pass_count++;
        w_out_ack = 1'b1;
        @(negedge clk);
        w_out_ack = 1'b0;
        check_count++;
        if (w_overflow !== 1'b1 || w_out_valid !== 1'b0)
            $display("[TB] FAIL wide_sticky: ovf=%b valid=%b expected 1 0", w_overflow, w_out_valid);
        else pass_count++;
        w_start = 1'b1;
        @(negedge clk);
        w_start = 1'b0;
        check_count++;
        if (w_overflow !== 1'b0 || w_in_ready !== 1'b1)
            $display("[TB] FAIL wide_clear: ovf=%b rdy=%b expected 0 1", w_overflow, w_in_ready);
        else pass_count++;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ack = 1'b0;
        w_start = 1'b0; w_in_valid = 1'b0; w_in_data = 11'h000; w_out_ack = 1'b0;
        @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_basic_burst();
        test_max_values();
        test_bubbles();
        test_ignored_events();
        test_async_reset();
        test_overflow();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/sample_accumulator.md
# sample_accumulator

Sequential front end for the 11-bit ripple-carry adder (ElevenBitFullAdder). It accepts a burst of unsigned 8-bit samples over a valid/ready handshake and drives the adder with the running total and the current sample. It registers the adder's Sum back into the accumulator and presents the final 11-bit total with its own valid/ack handshake. With the default parameters, 8 × 255 = 2040 fits exactly in 11 bits.

## Interface
- N_SAMPLES, default 8: samples per burst; legal range 1..255.
- DATA_W, default 8: sample width; zero-extended to 11 bits; legal range 1..11.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a burst; honoured only in IDLE.
- in_valid  in  1  upstream sample valid.
- in_data  in  DATA_W  sample value, unsigned.
- in_ready  out  1  asserted when a sample can be accepted.
- add_a  out  11  to adder A: current accumulator value.
- add_b  out  11  to adder B: {zeros, in_data}.
- add_cin  out  1  to adder Cin: constant 0.
- add_sum  in  11  from adder Sum.
- add_cout  in  1  from adder Cout.
- out_valid  out  1  final total valid.
- out_sum  out  11  final total; stable while out_valid is high.
- out_ack  in  1  downstream consumes the result.
- busy  out  1  high in ACCUM or DONE.
- overflow  out  1  sticky carry-out flag for the current burst.

## Operation
- States:
  - IDLE: in_ready=0, out_valid=0.
  - ACCUM: in_ready=1.
  - DONE: out_valid=1, in_ready=0.
- IDLE → ACCUM on start. Same edge: acc←0, count←0, overflow←0.
- ACCUM, on an accept (in_valid && in_ready): acc←add_sum, count←count+1, overflow←overflow | add_cout.
- ACCUM, no accept: acc and count hold. in_data is ignored when in_valid=0.
- ACCUM → DONE on the accept that makes count equal N_SAMPLES.
- DONE → IDLE on out_ack. acc, and therefore out_sum, keeps its value after leaving DONE.
- out_ack outside DONE: ignored.
- start in ACCUM or DONE: ignored. It does not restart the burst.
- add_a=acc and add_b=zero-extended in_data are continuous (combinational), so the adder result is valid in the same cycle.
- out_sum=acc, registered.
- overflow:
  - Defaults: can never set, since max 2040 < 2048.
  - Wider configurations: acc keeps the wrapped 11-bit value and overflow stays 1 until the next start.
- count is an 8-bit register.

## Timing
- Reset (async, immediate): state=IDLE, acc=0, count=0, overflow=0.
  - Outputs under reset: in_ready=0, out_valid=0, busy=0, out_sum=0, add_a=0, add_cin=0.
- Reset asserted mid-burst aborts the burst. No partial result is presented.
- start sampled at edge k gives in_ready=1 from cycle k+1.
- Throughput: one sample per cycle when in_valid is held high.
- Latency: the last sample is accepted at edge m, and out_valid=1 with the final out_sum from cycle m+1.
  - Minimum burst: start at edge 0, samples at edges 1..N, out_valid from cycle N+1.
- out_ack sampled at edge d gives out_valid=0 and busy=0 from cycle d+1. A new start is accepted at d+1 at the earliest.
- start arriving at the same edge as the DONE→IDLE transition is ignored, because the state at that edge is DONE.
- Adder path: one combinational ripple through 11 full adders, inside one clock period.

## Test plan
- Basic burst. Stimulus: start, then samples 1,2,...,8 back-to-back. Required: out_sum=36 and out_valid in the cycle after the 8th accept; overflow=0.
- Maximum values. Stimulus: 8 × 0xFF. Required: out_sum=2040 (0x7F8), overflow=0, add_cin=0 throughout.
- Bubbles and backpressure on the output. Stimulus: samples 10,0,200,5,5,5,5,5 with in_valid dropped for 3 cycles between samples; out_ack held low 5 cycles. Required: out_sum=235, stable and valid for all 5 cycles; busy=1 until the cycle after ack.
- Ignored events.
  - start pulsed mid-ACCUM: count is not reset.
  - start pulsed in DONE: no effect.
  - out_ack pulsed in IDLE: no effect.
  - Next burst of 8 × 1: out_sum=8.
- Async reset. Stimulus: rst asserted between clock edges after 4 samples. Required: in_ready, out_valid, busy and out_sum go to 0 immediately; the next burst of 8 × 3 gives out_sum=24.
- Overflow (DATA_W=11, N_SAMPLES=2). Stimulus: samples 0x7FF, 0x002. Required: out_sum=0x001, overflow=1; overflow clears on the next start.
